seq_restoring_divider: RTL and testbench

//   Unsigned multi-cycle divider using the restoring shift-subtract algorithm, one quotient bit per clock.
//   It is the inverse companion of the lab adder/multiplier datapaths.
//   The WIDTH+1-bit subtract/compare stage is built structurally from the team gate library
//   (xor2, and2, or2, and3, or3, and4, or4 only).

---
 rtl/seq_restoring_divider.sv | 169 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// The WIDTH+1-bit trial subtraction is a ripple-borrow chain built from library gates.

module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module or3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a | b | c;
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   sub_a;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH-1:0] diff;
    logic [WIDTH+1:0] borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign sub_a     = {r_q, q_q[WIDTH-1]};
    assign sub_b     = {1'b0, d_q};
    assign borrow[0] = 1'b0;

    // Each stage: diff = a^b^bin, bout = ~a&b | ~a&bin | b&bin (inversion via xor with 1).
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        logic na, t_ab, t_ai, t_bi;
        xor2 u_inv (.a(sub_a[i]), .b(1'b1),      .y(na));
        and2 u_ab  (.a(na),       .b(sub_b[i]),  .y(t_ab));
        and2 u_ai  (.a(na),       .b(borrow[i]), .y(t_ai));
        and2 u_bi  (.a(sub_b[i]), .b(borrow[i]), .y(t_bi));
        or3  u_bo  (.a(t_ab), .b(t_ai), .c(t_bi), .y(borrow[i+1]));
        if (i < WIDTH) begin : g_diff
            logic x_ab;
            xor2 u_x0 (.a(sub_a[i]), .b(sub_b[i]),  .y(x_ab));
            xor2 u_x1 (.a(x_ab),     .b(borrow[i]), .y(diff[i]));
        end
    end

    always_comb begin
        if (!borrow[WIDTH+1]) begin
            r_next = diff;
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = q_next;
                    remainder_d = r_next;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of the 8-bit restoring divider against hand-computed results.

module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    int busyCnt;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drives start at the current negedge and waits (bounded) for done; optionally pulses start mid-run.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int pulseAt);
        logic gotDone;
        gotDone  = 1'b0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        busyCnt  = 0;
        for (int i = 1; i <= 40 && !gotDone; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == pulseAt) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (i == pulseAt + 1) start = 1'b0;
            if (busy) busyCnt++;
            if (done) begin
                gotDone = 1'b1;
                lat     = i;
            end
        end
        checkOutput("done_seen", {31'd0, gotDone}, 32'd1);
    endtask

    task automatic checkResult(input string tag, input int expQ, input int expR, input int expZ, input int expLat);
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_q"}, {24'd0, quotient}, expQ);
        checkOutput({tag, "_r"}, {24'd0, remainder}, expR);
        checkOutput({tag, "_dbz"}, {31'd0, div_by_zero}, expZ);
    endtask

    logic [7:0] extA [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] extB [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    int         extQ [4] = '{255, 0, 1, 0};
    int         extR [4] = '{0,   5, 0, 0};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_q", {24'd0, quotient}, 0);
        checkOutput("rst_r", {24'd0, remainder}, 0);
        checkOutput("rst_dbz", {31'd0, div_by_zero}, 0);

        $display("[TB] basic 100/7");
        applyStimulus(8'd100, 8'd7, 0);
        checkResult("t1", 14, 2, 0, 9);
        checkOutput("t1_busy_cycles", busyCnt, 8);
        @(negedge clk);
        checkOutput("t1_done_pulse", {31'd0, done}, 0);
        checkOutput("t1_q_held", {24'd0, quotient}, 14);

        $display("[TB] extremes");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(extA[k], extB[k], 0);
            checkResult($sformatf("ext%0d", k), extQ[k], extR[k], 0, 9);
            @(negedge clk);
        end

        $display("[TB] divide by zero");
        applyStimulus(8'd77, 8'd0, 0);
        checkResult("dbz", 255, 77, 1, 1);
        @(negedge clk);
        checkOutput("dbz_done_pulse", {31'd0, done}, 0);
        checkOutput("dbz_held", {31'd0, div_by_zero}, 1);
        applyStimulus(8'd10, 8'd3, 0);
        checkResult("after_dbz", 3, 1, 0, 9);
        @(negedge clk);

        $display("[TB] start pulsed while busy");
        applyStimulus(8'd100, 8'd7, 4);
        checkResult("midstart", 14, 2, 0, 9);
        @(negedge clk);
        checkOutput("midstart_idle", {31'd0, busy}, 0);

        $display("[TB] reset mid-division");
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 0);
        checkOutput("abort_done", {31'd0, done}, 0);
        checkOutput("abort_q", {24'd0, quotient}, 0);
        checkOutput("abort_r", {24'd0, remainder}, 0);
        repeat (12) @(negedge clk);
        checkOutput("abort_no_done", {31'd0, done}, 0);
        applyStimulus(8'd200, 8'd3, 0);
        checkResult("rerun", 66, 2, 0, 9);
        @(negedge clk);

        $display("[TB] back-to-back");
        applyStimulus(8'd100, 8'd7, 0);
        checkResult("b2b_first", 14, 2, 0, 9);
        applyStimulus(8'd9, 8'd2, 0);
        checkResult("b2b_second", 4, 1, 0, 9);
        @(negedge clk);

        $display("[TB] random pairs");
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            applyStimulus(a, b, 0);
            checkOutput($sformatf("rnd%0d_q(%0d/%0d)", n, a, b), {24'd0, quotient}, a / b);
            checkOutput($sformatf("rnd%0d_r(%0d/%0d)", n, a, b), {24'd0, remainder}, a % b);
            checkOutput($sformatf("rnd%0d_lat", n), lat, 9);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
